// File: rtl/systolic_feeder.sv
// systolic_feeder: buffers one tile of K vectors (N signed lanes each) and
// streams it into the edge PEs of a systolic MAC array as a diagonally
// skewed wavefront. Lane i lags lane 0 by i cycles; idle lane slots are zero.
// A one-cycle acc_clear precedes each tile and a one-cycle done follows it.
module systolic_feeder #(
    parameter int data_size = 8,
    parameter int N         = 4,
    parameter int K         = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [N*data_size-1:0] in_data,
    output logic                   acc_clear,
    output logic                   a_valid,
    output logic [N*data_size-1:0] a_out,
    output logic                   done
);

    localparam int CW = (K > 1) ? $clog2(K) : 1;
    localparam int TW = $clog2(K + N);

    localparam logic [CW-1:0] LOAD_LAST = CW'(K - 1);
    localparam logic [TW-1:0] T_LAST    = TW'(K + N - 2);

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_CLEAR  = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]             state_q, state_d;
    logic [CW-1:0]          load_cnt_q, load_cnt_d;
    logic [TW-1:0]          t_q, t_d;
    logic                   acc_clear_q, acc_clear_d;
    logic                   a_valid_q, a_valid_d;
    logic [N*data_size-1:0] a_out_q, a_out_d;
    logic                   done_q, done_d;
    logic [N*data_size-1:0] buf_q [K];
    logic                   accept;

    assign in_ready  = (state_q == S_LOAD);
    assign accept    = in_valid && in_ready;
    assign acc_clear = acc_clear_q;
    assign a_valid   = a_valid_q;
    assign a_out     = a_out_q;
    assign done      = done_q;

    // Next-state logic; outputs are derived from the next state/time step so
    // that the registered outputs line up with the state they describe.
    always_comb begin
        int diff;
        diff       = 0;
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        t_d        = t_q;
        done_d     = 1'b0;

        case (state_q)
            S_LOAD: begin
                if (accept) begin
                    if (load_cnt_q == LOAD_LAST) begin
                        load_cnt_d = '0;
                        state_d    = S_CLEAR;
                    end else begin
                        load_cnt_d = load_cnt_q + 1'b1;
                    end
                end
            end
            S_CLEAR: begin
                state_d = S_STREAM;
                t_d     = '0;
            end
            S_STREAM: begin
                if (t_q == T_LAST) begin
                    state_d = S_LOAD;
                    t_d     = '0;
                    done_d  = 1'b1;
                end else begin
                    t_d = t_q + 1'b1;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase

        acc_clear_d = (state_d == S_CLEAR);
        a_valid_d   = (state_d == S_STREAM);

        // Lane i at step t carries beat t-i; outside the tile it is zero.
        a_out_d = '0;
        if (a_valid_d) begin
            for (int unsigned i = 0; i < N; i++) begin
                diff = int'(t_d) - int'(i);
                if (diff >= 0 && diff < K) begin
                    a_out_d[i*data_size +: data_size] =
                        buf_q[CW'(diff)][i*data_size +: data_size];
                end
            end
        end
    end

    // Control and output registers with synchronous reset; reset aborts a tile.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_LOAD;
            load_cnt_q  <= '0;
            t_q         <= '0;
            acc_clear_q <= 1'b0;
            a_valid_q   <= 1'b0;
            a_out_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_cnt_q  <= load_cnt_d;
            t_q         <= t_d;
            acc_clear_q <= acc_clear_d;
            a_valid_q   <= a_valid_d;
            a_out_q     <= a_out_d;
            done_q      <= done_d;
        end
    end

    // Tile buffer: accepted beats are written in arrival order, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[load_cnt_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (N=4, K=4, 8-bit lanes). Expected
// wavefronts are computed from the loaded tile and queued; each streamed
// cycle pops one entry and compares it with a_out.
module tb_systolic_feeder;

    localparam int DW = 8;
    localparam int N  = 4;
    localparam int K  = 4;
    localparam int W  = N * DW;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         acc_clear;
    logic         a_valid;
    logic [W-1:0] a_out;
    logic         done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_clr = 0;
    int c1;

    logic [W-1:0] tile [K];
    logic [W-1:0] seen [K+N-1];
    logic [W-1:0] exp_q [$];

    systolic_feeder #(.data_size(DW), .N(N), .K(K)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .acc_clear(acc_clear),
        .a_valid  (a_valid),
        .a_out    (a_out),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "simulation time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic set_tile(input int base, input int stride);
        for (int j = 0; j < K; j++)
            for (int i = 0; i < N; i++)
                tile[j][i*DW +: DW] = 8'(base + stride * j + i);
    endtask

    // Load the current tile (gap idle cycles between beats), then check the
    // clear cycle, the K+N-1 stream cycles and the done cycle. abort_at >= 0
    // asserts reset during that stream step instead of finishing the tile.
    task automatic run_tile(input int gap, input bit noise, input int abort_at);
        logic [W-1:0] v;
        logic [W-1:0] e;
        for (int t = 0; t < K + N - 1; t++) begin
            v = '0;
            for (int i = 0; i < N; i++)
                if (t - i >= 0 && t - i < K)
                    v[i*DW +: DW] = tile[t-i][i*DW +: DW];
            exp_q.push_back(v);
        end

        for (int j = 0; j < K; j++) begin
            in_valid = 1'b1;
            in_data  = tile[j];
            chk("in_ready_load", in_ready, 1);
            step();
            in_valid = 1'b0;
            in_data  = '0;
            if (j < K - 1) begin
                for (int g = 0; g < gap; g++) begin
                    chk("acc_clear_gap", acc_clear, 0);
                    step();
                end
            end
        end

        chk("acc_clear_hi", acc_clear, 1);
        chk("a_valid_clear", a_valid, 0);
        chk("a_out_clear", a_out, 0);
        chk("in_ready_clear", in_ready, 0);
        last_clr = cyc;
        if (noise) begin
            in_valid = 1'b1;
            in_data  = 32'hDEADBEEF;
        end
        step();

        for (int t = 0; t < K + N - 1; t++) begin
            e = exp_q.size() > 0 ? exp_q.pop_front() : 'x;
            chk("a_valid_stream", a_valid, 1);
            chk($sformatf("a_out_t%0d", t), a_out, e);
            chk("acc_clear_stream", acc_clear, 0);
            chk("in_ready_stream", in_ready, 0);
            seen[t] = a_out;
            if (t == abort_at) begin
                reset = 1'b1;
                in_valid = 1'b0;
                step();
                reset = 1'b0;
                chk("rst_a_valid", a_valid, 0);
                chk("rst_a_out", a_out, 0);
                chk("rst_acc_clear", acc_clear, 0);
                chk("rst_done", done, 0);
                chk("rst_in_ready", in_ready, 1);
                exp_q.delete();
                step();
                chk("rst_done_after", done, 0);
                chk("rst_a_valid_after", a_valid, 0);
                return;
            end
            step();
        end
        in_valid = 1'b0;
        in_data  = '0;

        chk("done_hi", done, 1);
        chk("a_valid_done", a_valid, 0);
        chk("a_out_done", a_out, 0);
        chk("in_ready_done", in_ready, 1);
        chk("acc_clear_done", acc_clear, 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        step();
        step();
        reset = 1'b0;
        chk("reset_in_ready", in_ready, 1);
        chk("reset_acc_clear", acc_clear, 0);
        chk("reset_a_valid", a_valid, 0);
        chk("reset_a_out", a_out, 0);
        chk("reset_done", done, 0);
        step();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_a_valid", a_valid, 0);
        chk("idle_done", done, 0);

        // Basic skew: beat j lane i = 16j+i+1.
        set_tile(1, 16);
        run_tile(0, 1'b0, -1);
        chk("skew_t0", seen[0], 32'h00000001);
        chk("skew_t3", seen[3], 32'h04132231);
        chk("skew_t6", seen[6], 32'h34000000);
        step();

        // Signed passthrough: -128 on beat 0, 127 on beats 1-3.
        for (int i = 0; i < N; i++) begin
            tile[0][i*DW +: DW] = 8'h80;
            for (int j = 1; j < K; j++)
                tile[j][i*DW +: DW] = 8'h7F;
        end
        run_tile(0, 1'b0, -1);
        chk("signed_lane1_diag", seen[1][15:8], 8'h80);
        chk("signed_lane1_next", seen[4][15:8], 8'h7F);
        chk("signed_lane3_diag", seen[3][31:24], 8'h80);
        step();

        // One idle cycle between beats, in_valid noise during the clear/stream.
        set_tile(1, 16);
        run_tile(1, 1'b1, -1);
        set_tile(8'hA0, 4);
        run_tile(0, 1'b0, -1);
        step();

        // Reset at stream step 2, then a fresh tile.
        set_tile(3, 7);
        run_tile(0, 1'b0, 2);
        set_tile(5, 11);
        run_tile(0, 1'b0, -1);
        step();

        // Back-to-back tiles with continuous valid.
        set_tile(1, 16);
        run_tile(0, 1'b0, -1);
        c1 = last_clr;
        chk("b2b_done_with_beat0", done & in_ready, 1);
        set_tile(9, 13);
        run_tile(0, 1'b0, -1);
        chk("b2b_clear_period", 64'(last_clr - c1), 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
